// File: rtl/multi_sprite_gen.sv
// Multi-channel sprite overlay: frame-synchronous position shadowing, ROM addressing,
// colour-key transparency and fixed priority compose. Optional: SPRITE_COLLISION_EN.
module multi_sprite_gen #(
  parameter int unsigned N_SPR      = 2,
  parameter int unsigned SPR_W_LOG2 = 5,
  parameter int unsigned SPR_H_LOG2 = 5,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [11:0] KEY_RGB    = 12'hF0F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [11:0]              rgb_in,
  input  logic [N_SPR*10-1:0]      pos_x_in,
  input  logic [N_SPR*10-1:0]      pos_y_in,
  input  logic [N_SPR-1:0]         pos_valid_in,
  input  logic [N_SPR-1:0]         spr_en_in,
  output logic [N_SPR*ADDR_W-1:0]  rom_addr_out,
  input  logic [N_SPR*12-1:0]      rom_data_in,
  output logic [10:0]              hcount_out,
  output logic [9:0]               vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [11:0]              rgb_out,
  output logic                     hit_valid_out,
  output logic [2:0]               hit_id_out,
  output logic [N_SPR-1:0]         collision_out
);

  localparam int unsigned SprW = 1 << SPR_W_LOG2;
  localparam int unsigned SprH = 1 << SPR_H_LOG2;
  localparam int unsigned TimW = 25;

  logic                     vblnk_dly_q;
  logic                     frame_start;
  logic [N_SPR-1:0][9:0]    pend_x_q, pend_y_q, act_x_q, act_y_q;
  logic [N_SPR-1:0]         pend_en_q, act_en_q;
  logic [N_SPR-1:0]         hit_d, hit1_q, hit2_q, opaque;
  logic [N_SPR*ADDR_W-1:0]  addr_d, rom_addr_q;
  logic [TimW-1:0]          tim_d, tim1_q, tim2_q, tim3_q;
  logic [11:0]              rgb1_q, rgb2_q, rgb_d, rgb_q;
  logic                     hv_d, hv_q;
  logic [2:0]               id_d, id_q;

  assign frame_start = vblnk_in & ~vblnk_dly_q;
  assign tim_d = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  // Stage 1 hit test at 12 bits so x + width never wraps
  for (genvar g = 0; g < N_SPR; g++) begin : g_ch
    logic [11:0]           h12, v12, x12, y12;
    logic                  in_x, in_y;
    logic [SPR_W_LOG2-1:0] dx;
    logic [SPR_H_LOG2-1:0] dy;

    assign h12  = {1'b0, hcount_in};
    assign v12  = {2'b00, vcount_in};
    assign x12  = {2'b00, act_x_q[g]};
    assign y12  = {2'b00, act_y_q[g]};
    assign in_x = (h12 >= x12) && (h12 < x12 + 12'(SprW));
    assign in_y = (v12 >= y12) && (v12 < y12 + 12'(SprH));
    // Low address bits only need a modular difference
    assign dx   = hcount_in[SPR_W_LOG2-1:0] - act_x_q[g][SPR_W_LOG2-1:0];
    assign dy   = vcount_in[SPR_H_LOG2-1:0] - act_y_q[g][SPR_H_LOG2-1:0];

    assign hit_d[g] = act_en_q[g] & ~hblnk_in & ~vblnk_in & in_x & in_y;
    assign addr_d[g*ADDR_W +: ADDR_W] = hit_d[g] ? ADDR_W'({dy, dx}) : '0;
    assign opaque[g] = hit2_q[g] && (rom_data_in[g*12 +: 12] != KEY_RGB);
  end

  always_comb begin
    rgb_d = rgb2_q;
    hv_d  = 1'b0;
    id_d  = 3'd0;
    // Descending scan so the lowest opaque index is applied last and wins
    for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        rgb_d = rom_data_in[i*12 +: 12];
        hv_d  = 1'b1;
        id_d  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_dly_q <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_en_q   <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_en_q    <= '0;
      hit1_q      <= '0;
      hit2_q      <= '0;
      rom_addr_q  <= '0;
      tim1_q      <= '0;
      tim2_q      <= '0;
      tim3_q      <= '0;
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      rgb_q       <= '0;
      hv_q        <= 1'b0;
      id_q        <= 3'd0;
    end else begin
      vblnk_dly_q <= vblnk_in;
      for (int i = 0; i < int'(N_SPR); i++) begin
        // Active takes the old pending value even if a write lands on the boundary
        if (frame_start) begin
          act_x_q[i]  <= pend_x_q[i];
          act_y_q[i]  <= pend_y_q[i];
          act_en_q[i] <= pend_en_q[i];
        end
        if (pos_valid_in[i]) begin
          pend_x_q[i]  <= pos_x_in[i*10 +: 10];
          pend_y_q[i]  <= pos_y_in[i*10 +: 10];
          pend_en_q[i] <= spr_en_in[i];
        end
      end
      hit1_q     <= hit_d;
      hit2_q     <= hit1_q;
      rom_addr_q <= addr_d;
      tim1_q     <= tim_d;
      tim2_q     <= tim1_q;
      tim3_q     <= tim2_q;
      rgb1_q     <= rgb_in;
      rgb2_q     <= rgb1_q;
      rgb_q      <= rgb_d;
      hv_q       <= hv_d;
      id_q       <= id_d;
    end
  end

  assign rom_addr_out  = rom_addr_q;
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim3_q;
  assign rgb_out       = rgb_q;
  assign hit_valid_out = hv_q;
  assign hit_id_out    = id_q;

`ifdef SPRITE_COLLISION_EN
  logic [N_SPR-1:0] coll_now, coll_acc_q, coll_q;

  for (genvar g = 0; g < N_SPR; g++) begin : g_coll
    assign coll_now[g] = opaque[g] & (|(opaque & ~(N_SPR'(1) << g)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_acc_q <= '0;
      coll_q     <= '0;
    end else if (frame_start) begin
      coll_q     <= coll_acc_q;
      coll_acc_q <= coll_now;
    end else begin
      coll_acc_q <= coll_acc_q | coll_now;
    end
  end

  assign collision_out = coll_q;
`else
  assign collision_out = '0;
`endif

endmodule

// File: tb/tb_multi_sprite_gen.sv
// Directed bench for multi_sprite_gen with a 1-cycle registered sprite ROM model.
module tb_multi_sprite_gen;

  localparam int N = 2;
`ifdef SPRITE_COLLISION_EN
  localparam logic [1:0] CollHit = 2'b11;
`else
  localparam logic [1:0] CollHit = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]   rgb_in;
  logic [N*10-1:0] pos_x_in, pos_y_in;
  logic [N-1:0]  pos_valid_in, spr_en_in;
  logic [N*10-1:0] rom_addr_out;
  logic [N*12-1:0] rom_data_in;
  logic [10:0]   hcount_out;
  logic [9:0]    vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]   rgb_out;
  logic          hit_valid_out;
  logic [2:0]    hit_id_out;
  logic [N-1:0]  collision_out;

  logic key_mode = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  multi_sprite_gen #(.N_SPR(N)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .pos_valid_in(pos_valid_in),
    .spr_en_in(spr_en_in),
    .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hit_valid_out(hit_valid_out), .hit_id_out(hit_id_out),
    .collision_out(collision_out)
  );

  always #5 clk = ~clk;

  // ch0: solid 0A0, key colour at column 15 when key_mode; ch1: solid 00B
  always @(posedge clk) begin
    rom_data_in[11:0]  <= (key_mode && rom_addr_out[4:0] == 5'd15) ? 12'hF0F : 12'h0A0;
    rom_data_in[23:12] <= 12'h00B;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b1; vblnk_in = 1'b0; rgb_in = '0;
  endtask

  task automatic write(input int ch, input int x, input int y, input bit en);
    @(negedge clk);
    pos_x_in[ch*10 +: 10] = 10'(x);
    pos_y_in[ch*10 +: 10] = 10'(y);
    spr_en_in[ch] = en;
    pos_valid_in = '0;
    pos_valid_in[ch] = 1'b1;
    @(negedge clk);
    pos_valid_in = '0;
  endtask

  // One-cycle vblnk pulse; optionally a write to ch in the same (boundary) cycle
  task automatic frame(input bit wr, input int ch, input int x, input int y, input bit en);
    @(negedge clk);
    idle();
    vblnk_in = 1'b1;
    if (wr) begin
      pos_x_in[ch*10 +: 10] = 10'(x);
      pos_y_in[ch*10 +: 10] = 10'(y);
      spr_en_in[ch] = en;
      pos_valid_in[ch] = 1'b1;
    end
    @(negedge clk);
    pos_valid_in = '0;
    vblnk_in = 1'b0;
  endtask

  // Drive one pixel, then idle, and check the output three edges after capture
  task automatic probe(input string tag, input int h, input int v, input bit hb, input bit vb,
                       input logic [11:0] bg, input logic [11:0] er, input bit ehv,
                       input logic [2:0] eid);
    logic [10:0] hh;
    logic [9:0]  vv;
    hh = 11'(h);
    vv = 10'(v);
    @(negedge clk);
    hcount_in = hh; vcount_in = vv; hsync_in = hh[0]; vsync_in = vv[0];
    hblnk_in = hb; vblnk_in = vb; rgb_in = bg;
    @(negedge clk);
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(tag, 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                  rgb_out, hit_valid_out, hit_id_out}),
             64'({hh, vv, hh[0], vv[0], hb, vb, er, ehv, eid}));
  endtask

  initial begin
    rst = 1'b0;
    pos_valid_in = '0; spr_en_in = '0; pos_x_in = '0; pos_y_in = '0;
    idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hcount_in = 11'($urandom); vcount_in = 10'($urandom); rgb_in = 12'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
      pos_valid_in = 2'($urandom); spr_en_in = 2'($urandom);
      pos_x_in = 20'($urandom); pos_y_in = 20'($urandom);
    end
    @(posedge clk);
    #1;
    chk("reset_outs", 64'({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                           vblnk_out, rom_addr_out, hit_valid_out, hit_id_out, collision_out}),
        64'd0);
    @(negedge clk);
    pos_valid_in = '0; spr_en_in = '0;
    idle();
    rst = 1'b1;

    // Background pass-through with no channel enabled, even across a boundary
    probe("bg_pass", 300, 200, 0, 0, 12'h123, 12'h123, 0, 3'd0);
    frame(0, 0, 0, 0, 0);
    probe("bg_after_frame", 100, 50, 0, 0, 12'h456, 12'h456, 0, 3'd0);

    // Single sprite at (100,50)
    write(0, 100, 50, 1);
    probe("pending_hidden", 100, 50, 0, 0, 12'h111, 12'h111, 0, 3'd0);
    frame(0, 0, 0, 0, 0);
    probe("spr_tl", 100, 50, 0, 0, 12'h111, 12'h0A0, 1, 3'd0);
    probe("spr_br", 131, 81, 0, 0, 12'h111, 12'h0A0, 1, 3'd0);
    probe("spr_right_out", 132, 60, 0, 0, 12'h222, 12'h222, 0, 3'd0);
    probe("spr_left_out", 99, 60, 0, 0, 12'h333, 12'h333, 0, 3'd0);
    probe("spr_top_out", 110, 49, 0, 0, 12'h444, 12'h444, 0, 3'd0);
    probe("spr_bot_out", 110, 82, 0, 0, 12'h555, 12'h555, 0, 3'd0);
    probe("spr_hblnk", 110, 60, 1, 0, 12'h666, 12'h666, 0, 3'd0);
    @(negedge clk);
    hcount_in = 11'd101; vcount_in = 10'd51; hblnk_in = 1'b0; vblnk_in = 1'b0;
    @(posedge clk);
    #1;
    chk("addr_101_51", 64'(rom_addr_out), 64'({10'd0, 10'd33}));
    @(negedge clk);
    idle();

    // Transparency and priority with ch1 at (110,50)
    write(1, 110, 50, 1);
    frame(0, 0, 0, 0, 0);
    key_mode = 1'b1;
    probe("key_ch1_wins", 115, 50, 0, 0, 12'h777, 12'h00B, 1, 3'd1);
    probe("prio_ch0_wins", 116, 50, 0, 0, 12'h777, 12'h0A0, 1, 3'd0);
    key_mode = 1'b0;

    // Frame sync: mid-frame write, then a write coinciding with the boundary
    write(0, 200, 50, 1);
    probe("sync_old_pos", 100, 50, 0, 0, 12'h888, 12'h0A0, 1, 3'd0);
    probe("sync_new_hidden", 200, 50, 0, 0, 12'h888, 12'h888, 0, 3'd0);
    frame(1, 0, 300, 60, 1);
    probe("sync_new_drawn", 200, 50, 0, 0, 12'h999, 12'h0A0, 1, 3'd0);
    probe("sync_edge_hidden", 300, 60, 0, 0, 12'h999, 12'h999, 0, 3'd0);
    probe("sync_old_gone", 100, 50, 0, 0, 12'h999, 12'h999, 0, 3'd0);
    frame(0, 0, 0, 0, 0);
    probe("sync_edge_drawn", 300, 60, 0, 0, 12'hAAA, 12'h0A0, 1, 3'd0);
    probe("sync_prev_gone", 200, 50, 0, 0, 12'hAAA, 12'hAAA, 0, 3'd0);

    // Clipping at the bottom-right corner of a 640x480 screen
    write(1, 0, 0, 0);
    write(0, 630, 470, 1);
    frame(0, 0, 0, 0, 0);
    probe("clip_tl", 630, 470, 0, 0, 12'hBBB, 12'h0A0, 1, 3'd0);
    probe("clip_br", 639, 479, 0, 0, 12'hBBB, 12'h0A0, 1, 3'd0);
    probe("clip_left_out", 629, 470, 0, 0, 12'hBBB, 12'hBBB, 0, 3'd0);
    probe("clip_hblnk", 640, 475, 1, 0, 12'hCCC, 12'hCCC, 0, 3'd0);
    probe("clip_vblnk", 635, 480, 0, 1, 12'hDDD, 12'hDDD, 0, 3'd0);

    // Collision flags across two frames
    write(0, 100, 50, 1);
    write(1, 110, 50, 1);
    frame(0, 0, 0, 0, 0);
    chk("coll_clear", 64'(collision_out), 64'd0);
    probe("coll_overlap", 115, 50, 0, 0, 12'hEEE, 12'h0A0, 1, 3'd0);
    write(1, 300, 300, 1);
    frame(0, 0, 0, 0, 0);
    chk("coll_set", 64'(collision_out), 64'(CollHit));
    probe("coll_apart", 115, 50, 0, 0, 12'hEEE, 12'h0A0, 1, 3'd0);
    frame(0, 0, 0, 0, 0);
    chk("coll_cleared", 64'(collision_out), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_sprite_gen.md
Name: multi_sprite_gen

Overview:
- Parametrised successor of the single-tank draw path: overlays up to N_SPR independent sprites (tanks) on the VGA timing/RGB stream.
- Per-channel frame-synchronous position shadowing, sprite-ROM address generation for an external 1-cycle-latency ROM, colour-key transparency and fixed priority.
- Sits between the background/control stage and the mouse/cursor overlay, replacing the Control + draw_tank pair.

Parameters:
- N_SPR, 2, number of sprite channels (1..8)
- SPR_W_LOG2, 5, sprite width = 2**SPR_W_LOG2 pixels
- SPR_H_LOG2, 5, sprite height = 2**SPR_H_LOG2 lines
- ADDR_W, 10, ROM address width, must equal SPR_W_LOG2+SPR_H_LOG2
- KEY_RGB, 12'hF0F, transparent colour key

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  10  vertical line counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing inputs
- rgb_in  in  12  background pixel
- pos_x_in  in  N_SPR*10  per-channel top-left X, channel i at [10i+9:10i]
- pos_y_in  in  N_SPR*10  per-channel top-left Y
- pos_valid_in  in  N_SPR  per-channel write strobe for position/enable
- spr_en_in  in  N_SPR  per-channel visibility, sampled with pos_valid_in
- rom_addr_out  out  N_SPR*ADDR_W  per-channel ROM address
- rom_data_in  in  N_SPR*12  per-channel ROM pixel, valid one cycle after address
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/10/1/1/1/1  timing delayed by 3
- rgb_out  out  12  composited pixel
- hit_valid_out  out  1  a sprite pixel was drawn this cycle
- hit_id_out  out  3  index of the drawn channel
- collision_out  out  N_SPR  per-frame collision flags (optional feature)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-low. While rst=0, every output is 0, all pending/active registers are 0, and all channels are disabled.
- Pending registers: pos_valid_in[i]=1 loads channel i's X, Y and enable into its pending register. Nothing is visible until the next frame boundary.
- Frame boundary: rising edge of vblnk_in (vblnk_in=1 while the 1-cycle-delayed vblnk_in=0). On this edge, pending is copied to active for all channels.
- pos_valid_in coinciding with the boundary edge: the new value goes to pending only; active takes the previous pending value. The new value appears one frame later.
- Stage 1 (hit/address), per channel, all arithmetic at 12 bits with no wrap:
  - hit_i = en_i & ~hblnk & ~vblnk & hcount in [x, x+2**SPR_W_LOG2) & vcount in [y, y+2**SPR_H_LOG2).
  - Register addr_i = {vcount-y [SPR_H_LOG2-1:0], hcount-x [SPR_W_LOG2-1:0]}.
  - If hit_i=0, addr_i = 0.
  - Sprites extending past the screen edge are clipped naturally.
- Stage 2: ROM returns rom_data_in. hit_i and rgb_in are carried forward to align with it.
- Stage 3 (compose):
  - Channel i is opaque when hit_i=1 and rom_data_i != KEY_RGB.
  - Lowest-index opaque channel wins: rgb_out = its pixel, hit_valid_out=1, hit_id_out = that index.
  - If no channel is opaque: rgb_out = delayed rgb_in, hit_valid_out=0, hit_id_out=0.
- Latency: all outputs are registered. Timing and rgb have a fixed 3-cycle latency, including during blanking.
- Reset mid-frame: output is background-only from the first cycle after release until a frame boundary follows a pos_valid_in write.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- When defined:
  - A per-channel accumulator sets bit i whenever channel i is opaque in the same stage-3 cycle as any other opaque channel.
  - At the frame boundary, the accumulator is copied to collision_out and then cleared.
  - A collision in the boundary cycle itself is counted in the new frame.
- When not defined: collision_out is constant 0 and no accumulator logic exists.

Test Plan:
- Reset: hold rst=0 mid-line with random inputs -> all outputs 0; after release, rgb_out equals rgb_in delayed by 3 cycles while no channel is enabled.
- Single sprite: ch0 set to (100,50), en=1, followed by a vblnk edge; ROM returns 12'h0A0 -> rgb_out=0A0 exactly for hcount 100..131 and vcount 50..81, 3 cycles after those counts. Address at (101,51) = 10'd33.
- Transparency and priority: ch0 at (100,50), ch1 at (110,50), both enabled. ch0 ROM returns KEY_RGB at column 15 -> at hcount 115 the output is ch1's pixel with hit_id_out=1; at hcount 116 it is ch0's pixel with hit_id_out=0.
- Frame sync: pos_valid_in for ch0 to (200,50) asserted mid-frame, and again in the same cycle as a vblnk rising edge -> position is unchanged for the rest of the current frame; (200,50) is drawn one frame later.
- Clipping: ch0 at (630,470) on a 640x480 screen -> drawn only at hcount 630..639 and vcount 470..479; nothing drawn during hblnk/vblnk.
- SPRITE_COLLISION_EN: overlap ch0 and ch1 with opaque pixels -> collision_out=2'b11 after the next vblnk edge; move them apart -> 2'b00 the frame after.
